// File: rtl/led_pattern_sequencer.sv
// LED frame sequencer: builds animated frames (static/blink/chase/fill, alarm override)
// and writes them to the LED PIO over Avalon-MM only when the frame changes.
module led_pattern_sequencer #(
    parameter int unsigned LED_WIDTH   = 10,
    parameter int unsigned TICK_DIV    = 50000,
    parameter int unsigned ALARM_TICKS = 100
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [1:0]           mode,
    input  logic [LED_WIDTH-1:0] pattern,
    input  logic [15:0]          step_ticks,
    input  logic                 alarm_req,
    output logic [1:0]           avm_address,
    output logic                 avm_chipselect,
    output logic                 avm_write_n,
    output logic [31:0]          avm_writedata,
    output logic [LED_WIDTH-1:0] led_shadow,
    output logic                 busy
);

    localparam int unsigned IDX_W  = $clog2(LED_WIDTH + 1);
    localparam int unsigned TICK_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int unsigned ALM_W  = (ALARM_TICKS > 1) ? $clog2(ALARM_TICKS) : 1;

    localparam logic [TICK_W-1:0]  TICK_LAST  = TICK_W'(TICK_DIV - 1);
    localparam logic [ALM_W-1:0]   ALM_LAST   = ALM_W'(ALARM_TICKS - 1);
    localparam logic [IDX_W-1:0]   CHASE_LAST = IDX_W'(LED_WIDTH - 1);
    localparam logic [IDX_W-1:0]   FILL_LAST  = IDX_W'(LED_WIDTH);
    localparam logic [LED_WIDTH:0] ONE_W      = (LED_WIDTH + 1)'(1);

    typedef enum logic [1:0] {
        MODE_STATIC = 2'd0,
        MODE_BLINK  = 2'd1,
        MODE_CHASE  = 2'd2,
        MODE_FILL   = 2'd3
    } mode_e;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_WRITE = 1'b1
    } state_e;

    logic [TICK_W-1:0]    tick_cnt_q, tick_cnt_d;
    logic [15:0]          step_cnt_q, step_cnt_d;
    logic [IDX_W-1:0]     idx_q, idx_d;
    mode_e                mode_q, mode_d;
    logic                 alarm_dly_q, alarm_dly_d;
    logic                 alarm_ph_q, alarm_ph_d;
    logic [ALM_W-1:0]     alarm_cnt_q, alarm_cnt_d;
    state_e               state_q, state_d;
    logic                 cs_q, cs_d;
    logic                 write_n_q, write_n_d;
    logic                 busy_q, busy_d;
    logic [31:0]          writedata_q, writedata_d;
    logic [LED_WIDTH-1:0] shadow_q, shadow_d;

    logic                 tick;
    logic                 step;
    logic                 alarm_rise;
    logic [15:0]          step_lim;
    logic [LED_WIDTH:0]   fill_w;
    logic [LED_WIDTH-1:0] frame;

    // Tick, step and phase generation
    always_comb begin
        tick       = (tick_cnt_q == TICK_LAST);
        tick_cnt_d = tick ? '0 : tick_cnt_q + TICK_W'(1);
        step_lim   = (step_ticks == '0) ? 16'd1 : step_ticks;
        mode_d     = mode_e'(mode);
        step       = 1'b0;
        step_cnt_d = step_cnt_q;
        idx_d      = idx_q;
        if (mode_d != mode_q) begin
            step_cnt_d = '0;
            idx_d      = '0;
        end else if (tick) begin
            if (step_cnt_q >= step_lim - 16'd1) begin
                step_cnt_d = '0;
                step       = 1'b1;
            end else begin
                step_cnt_d = step_cnt_q + 16'd1;
            end
        end
        if (step) begin
            case (mode_q)
                MODE_BLINK: idx_d = idx_q ^ IDX_W'(1);
                MODE_CHASE: idx_d = (idx_q == CHASE_LAST) ? '0 : idx_q + IDX_W'(1);
                MODE_FILL:  idx_d = (idx_q == FILL_LAST) ? '0 : idx_q + IDX_W'(1);
                default:    idx_d = idx_q;
            endcase
        end
    end

    // Alarm phase counts only while the alarm is requested; a fresh request restarts lit
    always_comb begin
        alarm_dly_d = alarm_req;
        alarm_rise  = alarm_req & ~alarm_dly_q;
        alarm_ph_d  = alarm_ph_q;
        alarm_cnt_d = alarm_cnt_q;
        if (alarm_rise) begin
            alarm_ph_d  = 1'b1;
            alarm_cnt_d = '0;
        end else if (alarm_req && tick) begin
            if (alarm_cnt_q == ALM_LAST) begin
                alarm_cnt_d = '0;
                alarm_ph_d  = ~alarm_ph_q;
            end else begin
                alarm_cnt_d = alarm_cnt_q + ALM_W'(1);
            end
        end
    end

    always_comb begin
        fill_w = (ONE_W << idx_q) - ONE_W;
        frame  = pattern;
        if (alarm_req) begin
            frame = (alarm_rise || alarm_ph_q) ? '1 : '0;
        end else begin
            case (mode_q)
                MODE_STATIC: frame = pattern;
                MODE_BLINK:  frame = idx_q[0] ? '0 : pattern;
                MODE_CHASE:  frame = fill_w[LED_WIDTH-1:0] + LED_WIDTH'(1);
                MODE_FILL:   frame = fill_w[LED_WIDTH-1:0];
                default:     frame = pattern;
            endcase
        end
    end

    always_comb begin
        state_d     = state_q;
        cs_d        = 1'b0;
        write_n_d   = 1'b1;
        busy_d      = 1'b0;
        writedata_d = writedata_q;
        shadow_d    = shadow_q;
        case (state_q)
            ST_IDLE: begin
                if (frame != shadow_q) begin
                    writedata_d = 32'(frame);
                    cs_d        = 1'b1;
                    write_n_d   = 1'b0;
                    busy_d      = 1'b1;
                    state_d     = ST_WRITE;
                end
            end
            ST_WRITE: begin
                shadow_d = writedata_q[LED_WIDTH-1:0];
                state_d  = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            tick_cnt_q  <= '0;
            step_cnt_q  <= '0;
            idx_q       <= '0;
            mode_q      <= MODE_STATIC;
            alarm_dly_q <= 1'b0;
            alarm_ph_q  <= 1'b0;
            alarm_cnt_q <= '0;
            state_q     <= ST_IDLE;
            cs_q        <= 1'b0;
            write_n_q   <= 1'b1;
            busy_q      <= 1'b0;
            writedata_q <= '0;
            shadow_q    <= '0;
        end else begin
            tick_cnt_q  <= tick_cnt_d;
            step_cnt_q  <= step_cnt_d;
            idx_q       <= idx_d;
            mode_q      <= mode_d;
            alarm_dly_q <= alarm_dly_d;
            alarm_ph_q  <= alarm_ph_d;
            alarm_cnt_q <= alarm_cnt_d;
            state_q     <= state_d;
            cs_q        <= cs_d;
            write_n_q   <= write_n_d;
            busy_q      <= busy_d;
            writedata_q <= writedata_d;
            shadow_q    <= shadow_d;
        end
    end

    assign avm_address    = 2'b00;
    assign avm_chipselect = cs_q;
    assign avm_write_n    = write_n_q;
    assign avm_writedata  = writedata_q;
    assign led_shadow     = shadow_q;
    assign busy           = busy_q;

endmodule

// File: tb/tb_led_pattern_sequencer.sv
// Bench for led_pattern_sequencer: directed scenarios plus random stimulus, every cycle
// compared against a step-count based reference model.
module tb_led_pattern_sequencer;

    localparam int LW = 10;
    localparam int TD = 4;
    localparam int AT = 2;

    logic          clk = 1'b0;
    logic          reset;
    logic [1:0]    mode;
    logic [LW-1:0] pattern;
    logic [15:0]   step_ticks;
    logic          alarm_req;
    logic [1:0]    avm_address;
    logic          avm_chipselect;
    logic          avm_write_n;
    logic [31:0]   avm_writedata;
    logic [LW-1:0] led_shadow;
    logic          busy;

    led_pattern_sequencer #(
        .LED_WIDTH  (LW),
        .TICK_DIV   (TD),
        .ALARM_TICKS(AT)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .mode          (mode),
        .pattern       (pattern),
        .step_ticks    (step_ticks),
        .alarm_req     (alarm_req),
        .avm_address   (avm_address),
        .avm_chipselect(avm_chipselect),
        .avm_write_n   (avm_write_n),
        .avm_writedata (avm_writedata),
        .led_shadow    (led_shadow),
        .busy          (busy)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // Model state: time base, steps taken since the last mode change, ticks since alarm rise
    int            m_cyc;
    int            m_acc;
    int            m_steps;
    logic [1:0]    m_mode;
    logic          m_alarm_prev;
    int            m_alarm_tk;
    logic          m_cs;
    logic [LW-1:0] m_wdata;
    logic [LW-1:0] m_shadow;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=0x%0h exp=0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_cyc = 0; m_acc = 0; m_steps = 0; m_mode = 2'd0;
        m_alarm_prev = 1'b0; m_alarm_tk = 0;
        m_cs = 1'b0; m_wdata = '0; m_shadow = '0;
    endtask

    function automatic logic [LW-1:0] model_frame();
        int k;
        bit ph;
        if (alarm_req) begin
            ph = !m_alarm_prev || ((m_alarm_tk / AT) % 2 == 0);
            return ph ? {LW{1'b1}} : '0;
        end
        case (m_mode)
            2'd1:    return (m_steps % 2 == 0) ? pattern : '0;
            2'd2:    begin k = m_steps % LW;       return LW'(1 << k); end
            2'd3:    begin k = m_steps % (LW + 1); return LW'((1 << k) - 1); end
            default: return pattern;
        endcase
    endfunction

    task automatic model_step();
        logic [LW-1:0] f;
        bit tk;
        int lim;
        if (reset) begin
            model_reset();
            return;
        end
        f   = model_frame();
        tk  = (m_cyc % TD == TD - 1);
        lim = (step_ticks == 16'd0) ? 1 : int'(step_ticks);
        if (m_cs) begin
            m_cs = 1'b0;
            m_shadow = m_wdata;
        end else if (f != m_shadow) begin
            m_cs = 1'b1;
            m_wdata = f;
        end
        if (mode != m_mode) begin
            m_steps = 0; m_acc = 0;
        end else if (tk) begin
            m_acc++;
            if (m_acc >= lim) begin m_acc = 0; m_steps++; end
        end
        m_mode = mode;
        if (alarm_req && !m_alarm_prev) m_alarm_tk = 0;
        else if (alarm_req && tk)       m_alarm_tk++;
        m_alarm_prev = alarm_req;
        m_cyc++;
    endtask

    task automatic cycle();
        model_step();
        @(negedge clk);
        check_eq("chipselect", 32'(avm_chipselect), 32'(m_cs));
        check_eq("write_n",    32'(avm_write_n),    32'(!m_cs));
        check_eq("busy",       32'(busy),           32'(m_cs));
        check_eq("address",    32'(avm_address),    32'd0);
        check_eq("writedata",  avm_writedata,       32'(m_wdata));
        check_eq("led_shadow", 32'(led_shadow),     32'(m_shadow));
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) cycle();
    endtask

    initial begin
        int guard;
        reset = 1'b1; mode = 2'd0; pattern = '0; step_ticks = 16'd1; alarm_req = 1'b0;
        @(negedge clk);
        model_reset();
        run(2);
        reset = 1'b0;
        run(3);

        // Static frame written once, then held
        pattern = 10'h2A5;
        run(12);
        check_eq("static_shadow", 32'(led_shadow), 32'h2A5);

        // Blink
        mode = 2'd1; pattern = 10'h3FF; step_ticks = 16'd2;
        run(60);

        // Chase, full wrap
        mode = 2'd2; step_ticks = 16'd1;
        run(60);

        // Fill with step_ticks = 0
        mode = 2'd3; step_ticks = 16'd0;
        run(70);

        // Alarm over a chase in progress
        mode = 2'd2; step_ticks = 16'd1;
        run(2);
        guard = 0;
        while ((m_steps % LW != 5 || m_mode != 2'd2) && guard < 200) begin
            cycle();
            guard++;
        end
        check_eq("chase_idx5_reached", 32'(guard < 200), 32'd1);
        alarm_req = 1'b1;
        run(30);
        alarm_req = 1'b0;
        run(20);

        // Reset landing in the WRITE cycle
        pattern = 10'h155; mode = 2'd0;
        guard = 0;
        while (!m_cs && guard < 50) begin
            cycle();
            guard++;
        end
        check_eq("write_seen", 32'(m_cs), 32'd1);
        reset = 1'b1;
        cycle();
        check_eq("rst_abort_cs", 32'(avm_chipselect), 32'd0);
        check_eq("rst_abort_shadow", 32'(led_shadow), 32'd0);
        reset = 1'b0;
        pattern = '0;
        run(10);
        pattern = 10'h0F0;
        run(10);

        // Random stimulus
        for (int i = 0; i < 1500; i++) begin
            if ($urandom_range(0, 19) == 0) mode = 2'($urandom_range(0, 3));
            if ($urandom_range(0, 24) == 0) pattern = LW'($urandom);
            if ($urandom_range(0, 39) == 0) step_ticks = 16'($urandom_range(0, 3));
            if ($urandom_range(0, 59) == 0) alarm_req = ~alarm_req;
            reset = ($urandom_range(0, 299) == 0);
            cycle();
        end
        reset = 1'b0;
        run(5);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/led_pattern_sequencer.md
Name: led_pattern_sequencer

Overview:
- Avalon-MM write-only master that owns the 10-bit LED PIO output slave and is its only writer.
- Builds LED frames from a selected animation mode (static, blink, chase, fill bar) plus an alarm override.
- Issues a single-cycle PIO register write only when the frame differs from the last value written.
- Sits between the coffee-machine control logic (mode, pattern, alarm) and the LED PIO slave.

Parameters:
LED_WIDTH, 10, number of LEDs; equals the PIO data width.
TICK_DIV, 50000, clk cycles per base tick (1 ms at 50 MHz).
ALARM_TICKS, 100, base ticks per alarm blink half-period.

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-high reset
mode  in  2  0=static, 1=blink, 2=chase, 3=fill
pattern  in  LED_WIDTH  frame source for static and blink modes
step_ticks  in  16  base ticks per animation step; 0 is treated as 1
alarm_req  in  1  level; while high, overrides mode with an all-LED blink
avm_address  out  2  PIO register address; constant 0
avm_chipselect  out  1  high for exactly one cycle per write
avm_write_n  out  1  active-low write; low only while chipselect is high
avm_writedata  out  32  {zeros, frame}
led_shadow  out  LED_WIDTH  last value written to the PIO
busy  out  1  high during the WRITE state

Behaviour:
- Reset (one clock, synchronous):
  - All counters and phases clear to 0.
  - State goes to IDLE.
  - led_shadow = 0, which matches the PIO reset value, so no write is issued after reset.
  - avm_chipselect = 0, avm_write_n = 1, avm_writedata = 0, busy = 0.
  - Reset asserted during WRITE aborts the write: chipselect drops the next cycle.
- Tick generation:
  - tick_cnt counts 0..TICK_DIV-1 and wraps.
  - tick pulses for one cycle when tick_cnt = TICK_DIV-1.
- Step generation:
  - step_cnt increments on each tick.
  - When step_cnt reaches max(step_ticks,1)-1 and a tick occurs, step pulses and step_cnt clears.
  - A change to step_ticks takes effect at the next comparison; if step_cnt is already beyond the new limit, it clears on the next tick.
- Phase register (idx, width ceil(log2(LED_WIDTH+1))), advanced on step:
  - static: idx unused.
  - blink: idx[0] toggles.
  - chase: idx counts 0..LED_WIDTH-1, then wraps to 0.
  - fill: idx counts 0..LED_WIDTH, then wraps to 0.
  - Any cycle where mode differs from registered mode_q clears idx and step_cnt; tick_cnt is not cleared.
- Frame (combinational):
  - static: pattern.
  - blink: idx[0]=0 gives pattern; idx[0]=1 gives 0.
  - chase: 1<<idx.
  - fill: (1<<idx)-1, all ones when idx = LED_WIDTH.
  - alarm_req high: frame = alarm_ph ? all ones : 0, regardless of mode.
    - A rising edge of alarm_req sets alarm_ph = 1 and clears alarm_cnt.
    - alarm_ph toggles every ALARM_TICKS ticks.
    - Mode phase keeps advancing underneath, so mode animation resumes in progress when alarm_req falls.
- Write FSM:
  - IDLE: if frame != led_shadow, latch frame into avm_writedata and go to WRITE (registered outputs asserted the next cycle).
  - WRITE: lasts one cycle with chipselect=1, write_n=0, address=0; then led_shadow <= avm_writedata and go to IDLE.
  - The PIO slave has zero wait states, so no waitrequest is used.
  - Latency: 1 cycle from frame change to chipselect; writes are at least 2 cycles apart.
  - A frame change during WRITE is evaluated in the following IDLE cycle.
  - Intermediate frames shorter than 2 cycles may be skipped; the last stable frame is always written.
  - Outside WRITE: chipselect=0, write_n=1; writedata holds its last value.

Test Plan:
1. Reset, then mode=0, pattern=0x2A5 -> one write of 0x000002A5 at cycle 1 after the change; no further writes while inputs are held; led_shadow=0x2A5.
2. TICK_DIV=4, step_ticks=2, mode=1, pattern=0x3FF -> writes alternate 0x3FF and 0x000 every 8 cycles.
3. TICK_DIV=4, step_ticks=1, mode=2 -> writes 0x001, 0x002, ... 0x200, then 0x001, one every 4 cycles (wrap at index 9).
4. mode=3, step_ticks=0 (treated as 1) -> writes 0x001, 0x003, ... 0x3FF, 0x000, 0x001.
5. While mode=2 at idx=5, assert alarm_req with ALARM_TICKS=2 -> immediate write 0x3FF, then 0x000 after 2 ticks; release alarm_req -> next write is the chase frame at the advanced idx.
6. Assert reset in the WRITE cycle -> chipselect low the next cycle, led_shadow=0, no write until the frame next differs from 0.
